mem_access_stage: RTL

Memory-access pipeline stage of the MIPS32 core. It sits between the EX/MEM boundary and the synchronous-write data memory. It registers one load/store/pass-through request and checks alignment and range, then drives the memory port on the cycle the request advances. It returns write-back data and latches address-error exceptions (AdEL/AdES) for the interruption logic.

---
 rtl/mem_access_stage_pkg.sv | 16 +
 rtl/mem_align_check.sv | 35 +++
 rtl/mem_access_stage.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared constants for the memory-access stage: data-memory op codes and
// address-error exception codes.
package mem_access_stage_pkg;

  localparam int unsigned DM_OP_BIT = 3;

  localparam logic [DM_OP_BIT-1:0] DM_OP_WD = 3'd0;
  localparam logic [DM_OP_BIT-1:0] DM_OP_UH = 3'd1;
  localparam logic [DM_OP_BIT-1:0] DM_OP_UB = 3'd2;
  localparam logic [DM_OP_BIT-1:0] DM_OP_SH = 3'd3;
  localparam logic [DM_OP_BIT-1:0] DM_OP_SB = 3'd4;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

endpackage

// File: rtl/mem_align_check.sv
// Combinational alignment and range check for one memory request.
module mem_align_check
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned OP_W   = DM_OP_BIT
) (
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     addr,
  input  logic            load,
  input  logic            store,
  output logic            fault,
  output logic [4:0]      code
);

  logic misalign;
  logic range_err;
  logic unused_addr;

  assign unused_addr = ^addr[ADDR_W-1:2];
  assign range_err   = (addr[31:ADDR_W] != '0);

  always_comb begin
    misalign = 1'b0;
    case (op)
      OP_W'(DM_OP_WD):                  misalign = (addr[1:0] != 2'b00);
      OP_W'(DM_OP_UH), OP_W'(DM_OP_SH): misalign = addr[0];
      default:                          misalign = 1'b0;
    endcase
  end

  assign fault = (load | store) & (misalign | range_err);
  assign code  = store ? EXC_ADES : EXC_ADEL;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: request register R, write-back register W and a latched
// address-error exception that blocks new requests until acknowledged.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned OP_W   = DM_OP_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [OP_W-1:0]   in_op,
  input  logic [31:0]       in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [31:0]       in_alu,
  input  logic [4:0]        in_rd,
  input  logic [31:0]       in_pc,
  input  logic              flush,
  input  logic              wb_stall,
  output logic              dm_en,
  output logic              dm_w_en,
  output logic [OP_W-1:0]   dm_op,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  input  logic [31:0]       dm_dout,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              exc_valid,
  output logic [4:0]        exc_code,
  output logic [31:0]       exc_badvaddr,
  output logic [31:0]       exc_epc,
  input  logic              exc_ack
);

  logic            r_valid_q, r_load_q, r_store_q;
  logic [OP_W-1:0] r_op_q;
  logic [31:0]     r_addr_q, r_wdata_q, r_alu_q, r_pc_q;
  logic [4:0]      r_rd_q;

  logic            w_valid_q;
  logic [4:0]      w_rd_q;
  logic [31:0]     w_data_q;

  logic            exc_valid_q;
  logic [4:0]      exc_code_q;
  logic [31:0]     exc_badvaddr_q, exc_epc_q;

  logic            fault;
  logic [4:0]      fault_code;
  logic            memop, advance, accept, take_exc;

  mem_align_check #(
    .ADDR_W (ADDR_W),
    .OP_W   (OP_W)
  ) u_align (
    .op    (r_op_q),
    .addr  (r_addr_q),
    .load  (r_load_q),
    .store (r_store_q),
    .fault (fault),
    .code  (fault_code)
  );

  assign memop    = r_load_q | r_store_q;
  assign advance  = r_valid_q & ~wb_stall;
  assign in_ready = ~exc_valid_q & (~r_valid_q | advance);
  assign accept   = in_valid & in_ready;
  // A second fault behind a pending one is not allowed to overwrite it.
  assign take_exc = advance & fault & ~flush & (~exc_valid_q | exc_ack);

  assign dm_en   = advance & memop & ~fault & ~flush;
  assign dm_w_en = dm_en & r_store_q;
  assign dm_op   = r_op_q;
  assign dm_addr = r_addr_q[ADDR_W-1:0];
  assign dm_din  = r_wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_q <= 1'b0;
      r_load_q  <= 1'b0;
      r_store_q <= 1'b0;
      r_op_q    <= '0;
      r_addr_q  <= '0;
      r_wdata_q <= '0;
      r_alu_q   <= '0;
      r_rd_q    <= '0;
      r_pc_q    <= '0;
    end else if (flush) begin
      r_valid_q <= 1'b0;
    end else if (accept) begin
      r_valid_q <= 1'b1;
      r_load_q  <= in_load;
      r_store_q <= in_store;
      r_op_q    <= in_op;
      r_addr_q  <= in_addr;
      r_wdata_q <= in_wdata;
      r_alu_q   <= in_alu;
      r_rd_q    <= in_rd;
      r_pc_q    <= in_pc;
    end else if (advance) begin
      r_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_valid_q <= 1'b0;
      w_rd_q    <= '0;
      w_data_q  <= '0;
    end else if (flush) begin
      w_valid_q <= 1'b0;
    end else if (advance) begin
      if (fault) begin
        w_valid_q <= 1'b0;
      end else begin
        w_valid_q <= ~r_store_q;
        w_rd_q    <= r_rd_q;
        w_data_q  <= r_load_q ? dm_dout : r_alu_q;
      end
    end else if (!wb_stall) begin
      w_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exc_valid_q    <= 1'b0;
      exc_code_q     <= '0;
      exc_badvaddr_q <= '0;
      exc_epc_q      <= '0;
    end else if (take_exc) begin
      exc_valid_q    <= 1'b1;
      exc_code_q     <= fault_code;
      exc_badvaddr_q <= r_addr_q;
      exc_epc_q      <= r_pc_q;
    end else if (exc_valid_q && exc_ack) begin
      exc_valid_q <= 1'b0;
    end
  end

  assign wb_valid     = w_valid_q;
  assign wb_rd        = w_rd_q;
  assign wb_data      = w_data_q;
  assign exc_valid    = exc_valid_q;
  assign exc_code     = exc_code_q;
  assign exc_badvaddr = exc_badvaddr_q;
  assign exc_epc      = exc_epc_q;

endmodule
